// File: rtl/shift_rows_pipe.sv
// Registered AES ShiftRows/InvShiftRows for Nb = 4, 6 or 8 columns.
// The state is permuted on entry to a 2-entry valid/ready skid buffer.
module shift_rows_pipe #(
  parameter int unsigned NB    = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [32*NB-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TAG_W-1:0]   out_tag,
  output logic [32*NB-1:0]   out_data,
  output logic [1:0]         occupancy
);

  localparam int unsigned DW    = 32 * NB;
  localparam int unsigned OCC_W = 2;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("shift_rows_pipe: TAG_W must be at least 1");
  end

  // Row rotation amount; the wide 256-bit block uses the larger offsets.
  function automatic int unsigned f_shift(input int unsigned row);
    int unsigned sh;
    sh = row;
    if (NB == 8 && row >= 2) sh = row + 1;
    return sh;
  endfunction

  // Byte b = r + 4c sits at the MSB end; inverse rotates the other way.
  function automatic logic [DW-1:0] f_permute(input logic [DW-1:0] d, input logic inv);
    logic [DW-1:0] o;
    int unsigned   src;
    o = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < NB; c++) begin
        if (inv) src = (c + NB - f_shift(r)) % NB;
        else     src = (c + f_shift(r)) % NB;
        o[DW-1-8*(r+4*c) -: 8] = d[DW-1-8*(r+4*src) -: 8];
      end
    end
    return o;
  endfunction

  logic [OCC_W-1:0] r_occ;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [DW-1:0]    r_head_data;
  logic [TAG_W-1:0] r_head_tag;
  logic [DW-1:0]    r_tail_data;
  logic [TAG_W-1:0] r_tail_tag;

  logic             w_push;
  logic             w_pop;
  logic [DW-1:0]    w_perm;
  logic [OCC_W-1:0] w_occ_nxt;
  logic [DW-1:0]    w_head_data_nxt;
  logic [TAG_W-1:0] w_head_tag_nxt;
  logic [DW-1:0]    w_tail_data_nxt;
  logic [TAG_W-1:0] w_tail_tag_nxt;

  // Next-state: head/tail loads only on an accepted transfer, never on idle inputs.
  always_comb begin
    w_push          = in_valid & r_in_ready;
    w_pop           = r_out_valid & out_ready;
    w_perm          = f_permute(in_data, in_inv);
    w_occ_nxt       = r_occ;
    w_head_data_nxt = r_head_data;
    w_head_tag_nxt  = r_head_tag;
    w_tail_data_nxt = r_tail_data;
    w_tail_tag_nxt  = r_tail_tag;
    case (r_occ)
      2'd0: begin
        if (w_push) begin
          w_head_data_nxt = w_perm;
          w_head_tag_nxt  = in_tag;
          w_occ_nxt       = OCC_W'(1);
        end
      end
      2'd1: begin
        if (w_push && w_pop) begin
          w_head_data_nxt = w_perm;
          w_head_tag_nxt  = in_tag;
        end else if (w_push) begin
          w_tail_data_nxt = w_perm;
          w_tail_tag_nxt  = in_tag;
          w_occ_nxt       = OCC_W'(2);
        end else if (w_pop) begin
          w_occ_nxt       = OCC_W'(0);
        end
      end
      2'd2: begin
        if (w_pop) begin
          w_head_data_nxt = r_tail_data;
          w_head_tag_nxt  = r_tail_tag;
          w_occ_nxt       = OCC_W'(1);
        end
      end
      default: w_occ_nxt = OCC_W'(0);
    endcase
  end

  // Control and head-output registers; handshake flags follow next occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_head_data <= '0;
      r_head_tag  <= '0;
    end else begin
      r_occ       <= w_occ_nxt;
      r_in_ready  <= (w_occ_nxt != OCC_W'(2));
      r_out_valid <= (w_occ_nxt != OCC_W'(0));
      r_head_data <= w_head_data_nxt;
      r_head_tag  <= w_head_tag_nxt;
    end
  end

  // Second entry is never observed unless occupancy says so; no reset needed.
  always_ff @(posedge clk) begin
    r_tail_data <= w_tail_data_nxt;
    r_tail_tag  <= w_tail_tag_nxt;
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_head_data;
  assign out_tag   = r_head_tag;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed and scoreboarded bench for shift_rows_pipe at NB = 4, 6 and 8.
module tb_shift_rows_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic         v4, rdy4, inv4, ov4, ordy4;
  logic [3:0]   tag4, otag4;
  logic [127:0] d4, od4;
  logic [1:0]   occ4;

  logic         v6, rdy6, inv6, ov6, ordy6;
  logic [3:0]   tag6, otag6;
  logic [191:0] d6, od6;
  logic [1:0]   occ6;

  logic         v8, rdy8, inv8, ov8, ordy8;
  logic [3:0]   tag8, otag8;
  logic [255:0] d8, od8;
  logic [1:0]   occ8;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   t;
  } exp_t;

  shift_rows_pipe #(.NB(4), .TAG_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_inv(inv4),
    .in_tag(tag4), .in_data(d4), .out_valid(ov4), .out_ready(ordy4),
    .out_tag(otag4), .out_data(od4), .occupancy(occ4));

  shift_rows_pipe #(.NB(6), .TAG_W(4)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(rdy6), .in_inv(inv6),
    .in_tag(tag6), .in_data(d6), .out_valid(ov6), .out_ready(ordy6),
    .out_tag(otag6), .out_data(od6), .occupancy(occ6));

  shift_rows_pipe #(.NB(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_inv(inv8),
    .in_tag(tag8), .in_data(d8), .out_valid(ov8), .out_ready(ordy8),
    .out_tag(otag8), .out_data(od8), .occupancy(occ8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: split into a row/column byte grid, rotate each row, repack.
  function automatic logic [255:0] model(input logic [255:0] d, input int nb, input bit inv);
    logic [7:0]   st [4][8];
    int           sh [4];
    int           src;
    logic [255:0] o;
    sh[0] = 0; sh[1] = 1;
    sh[2] = (nb == 8) ? 3 : 2;
    sh[3] = (nb == 8) ? 4 : 3;
    o = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = d[32*nb-1-8*(r+4*c) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - sh[r] + nb) % nb : (c + sh[r]) % nb;
        o[32*nb-1-8*(r+4*c) -: 8] = st[r][src];
      end
    return o;
  endfunction

  function automatic logic [127:0] model4(input logic [127:0] d, input bit inv);
    logic [255:0] t;
    t = model(256'(d), 4, inv);
    return t[127:0];
  endfunction

  function automatic logic [191:0] model6(input logic [191:0] d, input bit inv);
    logic [255:0] t;
    t = model(256'(d), 6, inv);
    return t[191:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    checks++; if (occ4 !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occ4); end
    checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov4); end
    checks++; if (rdy4 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", rdy4); end
    checks++; if (od4 !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", od4); end
    checks++; if (otag4 !== 4'h0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", otag4); end
    checks++; if (od8 !== 256'h0) begin failures++; $display("FAIL reset_out_data8 got=%h exp=0", od8); end
    d4 = 'x; tag4 = 'x; v4 = 1'b0;
    tick(); tick();
    checks++; if (od4 !== 128'h0 || ov4 !== 1'b0) begin
      failures++; $display("FAIL idle_x_block got=%h/%b exp=0/0", od4, ov4);
    end
    d4 = '0; tag4 = '0;
  endtask

  task automatic test_fips_fwd_inv();
    ordy4 = 1'b1;
    v4 = 1'b1; inv4 = 1'b0; tag4 = 4'h5; d4 = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    tick();
    v4 = 1'b0;
    checks++; if (ov4 !== 1'b1) begin failures++; $display("FAIL fwd_valid got=%b exp=1", ov4); end
    checks++; if (od4 !== 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5) begin
      failures++; $display("FAIL fwd_data got=%h exp=d4bf5d30e0b452aeb84111f11e2798e5", od4);
    end
    checks++; if (otag4 !== 4'h5) begin failures++; $display("FAIL fwd_tag got=%h exp=5", otag4); end
    v4 = 1'b1; inv4 = 1'b1; tag4 = 4'ha; d4 = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    tick();
    v4 = 1'b0;
    checks++; if (od4 !== 128'hd42711ae_e0bf98f1_b8b45de5_1e415230 || otag4 !== 4'ha) begin
      failures++; $display("FAIL inv_data got=%h/%h exp=d42711aee0bf98f1b8b45de51e415230/a", od4, otag4);
    end
    tick();
    checks++; if (ov4 !== 1'b0 || occ4 !== 2'd0) begin
      failures++; $display("FAIL drain_empty got=%b/%0d exp=0/0", ov4, occ4);
    end
  endtask

  task automatic test_roundtrip();
    logic [127:0] x, y;
    ordy4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      v4 = 1'b1; inv4 = 1'b0; d4 = x; tag4 = 4'(k);
      tick();
      y = od4;
      checks++; if (y !== model4(x, 1'b0)) begin failures++; $display("FAIL rt_fwd got=%h exp=%h", y, model4(x, 1'b0)); end
      inv4 = 1'b1; d4 = y;
      tick();
      v4 = 1'b0;
      checks++; if (od4 !== x) begin failures++; $display("FAIL rt_identity got=%h exp=%h", od4, x); end
    end
    tick();
  endtask

  task automatic test_nb8();
    logic [255:0] seq, fwd;
    logic [7:0]   bv;
    for (int b = 0; b < 32; b++) seq[255-8*b -: 8] = 8'(b);
    ordy8 = 1'b1;
    v8 = 1'b1; inv8 = 1'b0; tag8 = 4'h7; d8 = seq;
    tick();
    v8 = 1'b0;
    fwd = od8;
    bv = fwd[255-8*0 -: 8];
    checks++; if (bv !== 8'h00) begin failures++; $display("FAIL nb8_byte0 got=%h exp=00", bv); end
    bv = fwd[255-8*1 -: 8];
    checks++; if (bv !== 8'h05) begin failures++; $display("FAIL nb8_byte1 got=%h exp=05", bv); end
    bv = fwd[255-8*3 -: 8];
    checks++; if (bv !== 8'h13) begin failures++; $display("FAIL nb8_byte3 got=%h exp=13", bv); end
    bv = fwd[255-8*7 -: 8];
    checks++; if (bv !== 8'h17) begin failures++; $display("FAIL nb8_byte7 got=%h exp=17", bv); end
    checks++; if (fwd !== model(seq, 8, 1'b0)) begin failures++; $display("FAIL nb8_fwd got=%h exp=%h", fwd, model(seq, 8, 1'b0)); end
    v8 = 1'b1; inv8 = 1'b1; d8 = fwd;
    tick();
    v8 = 1'b0;
    checks++; if (od8 !== seq) begin failures++; $display("FAIL nb8_inv got=%h exp=%h", od8, seq); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [191:0] s1, s2, s3;
    s1 = {6{32'h01020304}}; s2 = {6{32'ha5b6c7d8}}; s3 = {6{32'h0f1e2d3c}};
    s1[7:0] = 8'h99; s2[191:184] = 8'h11; s3[100 -: 8] = 8'h77;
    ordy6 = 1'b0; inv6 = 1'b0;
    v6 = 1'b1; tag6 = 4'd1; d6 = s1;
    tick();
    checks++; if (occ6 !== 2'd1 || rdy6 !== 1'b1) begin failures++; $display("FAIL bp_occ1 got=%0d/%b exp=1/1", occ6, rdy6); end
    tag6 = 4'd2; d6 = s2;
    tick();
    checks++; if (occ6 !== 2'd2 || rdy6 !== 1'b0) begin failures++; $display("FAIL bp_full got=%0d/%b exp=2/0", occ6, rdy6); end
    tag6 = 4'd3; d6 = s3;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (occ6 !== 2'd2 || otag6 !== 4'd1 || od6 !== model6(s1, 1'b0)) begin
        failures++; $display("FAIL bp_stall got=%0d/%0d/%h exp=2/1/%h", occ6, otag6, od6, model6(s1, 1'b0));
      end
    end
    ordy6 = 1'b1;
    tick();
    checks++; if (occ6 !== 2'd1 || otag6 !== 4'd2 || od6 !== model6(s2, 1'b0)) begin
      failures++; $display("FAIL bp_out2 got=%0d/%0d/%h exp=1/2/%h", occ6, otag6, od6, model6(s2, 1'b0));
    end
    tick();
    v6 = 1'b0;
    checks++; if (occ6 !== 2'd1 || otag6 !== 4'd3 || od6 !== model6(s3, 1'b0)) begin
      failures++; $display("FAIL bp_out3 got=%0d/%0d/%h exp=1/3/%h", occ6, otag6, od6, model6(s3, 1'b0));
    end
    tick();
    checks++; if (occ6 !== 2'd0 || ov6 !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0d/%b exp=0/0", occ6, ov6); end
  endtask

  task automatic test_push_pop_occ1();
    logic [127:0] a, b;
    a = 128'h00112233_44556677_8899aabb_ccddeeff;
    b = 128'hfedcba98_76543210_0f0e0d0c_0b0a0908;
    ordy4 = 1'b0; v4 = 1'b1; inv4 = 1'b0; tag4 = 4'h3; d4 = a;
    tick();
    ordy4 = 1'b1; inv4 = 1'b1; tag4 = 4'h4; d4 = b;
    tick();
    v4 = 1'b0;
    checks++; if (occ4 !== 2'd1 || otag4 !== 4'h4 || od4 !== model4(b, 1'b1)) begin
      failures++; $display("FAIL pushpop_occ1 got=%0d/%h/%h exp=1/4/%h", occ4, otag4, od4, model4(b, 1'b1));
    end
    tick();
  endtask

  // Streams through the NB=4 instance; checks each output transfer against a queue.
  task automatic test_stream(input int n_cycles, input bit random_mode);
    exp_t q[$];
    exp_t e;
    int   pushes;
    bit   do_push, do_pop;
    logic r0;
    pushes = 0;
    for (int i = 0; i < n_cycles; i++) begin
      if (random_mode) begin
        v4 = 1'($urandom_range(0, 1));
        ordy4 = 1'($urandom_range(0, 3) != 0);
        inv4 = 1'($urandom_range(0, 1));
      end else begin
        v4 = (pushes < 64);
        ordy4 = 1'b1;
        inv4 = 1'(pushes);
      end
      d4 = {$urandom, $urandom, $urandom, $urandom};
      tag4 = 4'($urandom);
      checks++; if (occ4 !== 2'(q.size()) || ov4 !== (q.size() > 0) || rdy4 !== (q.size() < 2)) begin
        failures++; $display("FAIL stream_flags got=%0d/%b/%b exp=%0d", occ4, ov4, rdy4, q.size());
      end
      #1;
      r0 = rdy4;
      ordy4 = ~ordy4;
      #1;
      checks++; if (rdy4 !== r0) begin failures++; $display("FAIL ready_comb_path got=%b exp=%b", rdy4, r0); end
      ordy4 = ~ordy4;
      #1;
      do_push = v4 && rdy4;
      do_pop = ov4 && ordy4;
      if (do_pop) begin
        e = q.pop_front();
        checks++; if (od4 !== e.d || otag4 !== e.t) begin
          failures++; $display("FAIL stream_data got=%h/%h exp=%h/%h", od4, otag4, e.d, e.t);
        end
      end
      if (do_push) begin
        e.d = model4(d4, inv4);
        e.t = tag4;
        q.push_back(e);
        pushes++;
      end
      tick();
    end
    v4 = 1'b0; ordy4 = 1'b1;
    while (q.size() > 0 && ov4 === 1'b1) begin
      e = q.pop_front();
      checks++; if (od4 !== e.d || otag4 !== e.t) begin
        failures++; $display("FAIL stream_drain got=%h/%h exp=%h/%h", od4, otag4, e.d, e.t);
      end
      tick();
    end
    checks++; if (q.size() != 0 || ov4 !== 1'b0) begin
      failures++; $display("FAIL stream_leftover got=%0d/%b exp=0/0", q.size(), ov4);
    end
  endtask

  task automatic test_reset_midstream();
    logic [127:0] c;
    ordy4 = 1'b0; v4 = 1'b1; inv4 = 1'b0;
    d4 = 128'h1; tag4 = 4'h1; tick();
    d4 = 128'h2; tag4 = 4'h2; tick();
    v4 = 1'b0;
    checks++; if (occ4 !== 2'd2) begin failures++; $display("FAIL rst_pre_full got=%0d exp=2", occ4); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (occ4 !== 2'd0 || ov4 !== 1'b0 || rdy4 !== 1'b1 || od4 !== 128'h0) begin
      failures++; $display("FAIL rst_mid got=%0d/%b/%b/%h exp=0/0/1/0", occ4, ov4, rdy4, od4);
    end
    c = 128'h63636363_7c7c7c7c_77777777_7b7b7b7b;
    ordy4 = 1'b1; v4 = 1'b1; inv4 = 1'b0; tag4 = 4'h9; d4 = c;
    tick();
    v4 = 1'b0;
    checks++; if (ov4 !== 1'b1 || od4 !== model4(c, 1'b0) || otag4 !== 4'h9) begin
      failures++; $display("FAIL rst_after got=%b/%h/%h exp=1/%h/9", ov4, od4, otag4, model4(c, 1'b0));
    end
    tick();
    checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL rst_after_drain got=%b exp=0", ov4); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    v4 = 0; inv4 = 0; tag4 = 0; d4 = 0; ordy4 = 0;
    v6 = 0; inv6 = 0; tag6 = 0; d6 = 0; ordy6 = 0;
    v8 = 0; inv8 = 0; tag8 = 0; d8 = 0; ordy8 = 0;
    test_reset();
    test_fips_fwd_inv();
    test_roundtrip();
    test_nb8();
    test_backpressure();
    test_push_pop_occ1();
    test_stream(70, 1'b0);
    test_stream(10000, 1'b1);
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
